real_block_avg: RTL



---
 rtl/real_block_avg_pkg.sv | 13 +
 rtl/real_block_avg.sv | 124 ++++++++++++
 2 files changed

// File: rtl/real_block_avg_pkg.sv
// Shared types and width helpers for the block mean/min/max reducer.
package real_block_avg_pkg;

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_e;

    function automatic int unsigned acc_width(input int unsigned width, input int unsigned log2_n);
        return width + log2_n;
    endfunction

endpackage

// File: rtl/real_block_avg.sv
// Reduces blocks of 2^log2_n accepted real samples to a registered rounded mean, minimum and maximum.
module real_block_avg
    import real_block_avg_pkg::*;
#(
    parameter int width    = 16,
    parameter int exponent = -8,
    parameter int log2_n   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [width-1:0]  in,
    input  logic                     in_valid,
    input  logic                     restart,
    output logic signed [width-1:0]  mean,
    output logic signed [width-1:0]  min,
    output logic signed [width-1:0]  max,
    output logic                     out_valid,
    output logic [15:0]              blocks
);

    localparam int unsigned aw = acc_width(width, log2_n);
    localparam int unsigned cw = log2_n;

    // Output format shares the input exponent, so the exponent only needs a sanity bound here.
    if (log2_n < 1 || log2_n > 8 || exponent < -1024 || exponent > 1024) begin : g_bad_param
        $error("real_block_avg: illegal parameter combination");
    end

    localparam logic [cw-1:0]        cnt_last = {cw{1'b1}};
    localparam logic signed [aw-1:0] half_lsb = aw'(1) <<< (log2_n - 1);

    logic [cw-1:0]              cnt_q, cnt_d;
    logic signed [aw-1:0]       acc_q, acc_d;
    logic signed [width-1:0]    cur_min_q, cur_min_d;
    logic signed [width-1:0]    cur_max_q, cur_max_d;
    logic signed [width-1:0]    mean_q, mean_d;
    logic signed [width-1:0]    min_q, min_d;
    logic signed [width-1:0]    max_q, max_d;
    logic                       out_valid_q, out_valid_d;
    logic [15:0]                blocks_q, blocks_d;

    state_e                     state;
    logic signed [aw-1:0]       in_ext;
    logic signed [aw-1:0]       sum;
    logic signed [aw-1:0]       rounded;
    logic signed [width-1:0]    nxt_min;
    logic signed [width-1:0]    nxt_max;

    // Next-state logic: restart and EMPTY both seed a fresh block from the incoming sample.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        cur_min_d   = cur_min_q;
        cur_max_d   = cur_max_q;
        mean_d      = mean_q;
        min_d       = min_q;
        max_d       = max_q;
        blocks_d    = blocks_q;
        out_valid_d = 1'b0;

        state   = (cnt_q == '0) ? EMPTY : FILLING;
        in_ext  = {{cw{in[width-1]}}, in};
        sum     = acc_q + in_ext;
        rounded = sum + half_lsb;
        nxt_min = (in < cur_min_q) ? in : cur_min_q;
        nxt_max = (in > cur_max_q) ? in : cur_max_q;

        if (in_valid) begin
            if (restart || state == EMPTY) begin
                acc_d     = in_ext;
                cur_min_d = in;
                cur_max_d = in;
                cnt_d     = cw'(1);
            end else if (cnt_q == cnt_last) begin
                mean_d      = width'(rounded >>> log2_n);
                min_d       = nxt_min;
                max_d       = nxt_max;
                out_valid_d = 1'b1;
                blocks_d    = blocks_q + 16'(1);
                cnt_d       = '0;
                acc_d       = '0;
            end else begin
                acc_d     = sum;
                cur_min_d = nxt_min;
                cur_max_d = nxt_max;
                cnt_d     = cnt_q + cw'(1);
            end
        end else if (restart) begin
            cnt_d = '0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            cur_min_q   <= '0;
            cur_max_q   <= '0;
            mean_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            blocks_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            cur_min_q   <= cur_min_d;
            cur_max_q   <= cur_max_d;
            mean_q      <= mean_d;
            min_q       <= min_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            blocks_q    <= blocks_d;
        end
    end

    assign mean      = mean_q;
    assign min       = min_q;
    assign max       = max_q;
    assign out_valid = out_valid_q;
    assign blocks    = blocks_q;

endmodule
